// File: rtl/graphics_pkg.sv
// Shared constants and types for the graphics pipeline: RGB332 palette,
// transparency key and playfield geometry.
package graphics_pkg;

    typedef logic [7:0] color_t;

    localparam color_t RED = 8'hE0;
    localparam color_t PNK = 8'hF3;
    localparam color_t CYN = 8'h1F;
    localparam color_t ORG = 8'hF4;
    localparam color_t YLW = 8'hFC;
    localparam color_t WHT = 8'hFF;
    localparam color_t CRM = 8'hFE;
    localparam color_t BLU = 8'h03;
    localparam color_t BLK = 8'h00;

    localparam color_t KEY_TRANSPARENT = 8'h00;

    localparam int PF_XMAX    = 240;
    localparam int PF_YMAX    = 320;
    localparam int PF_YOFFSET = 24;
    localparam int PF_MAZE_W  = 264;

endpackage

// File: rtl/graphics_priority_mux.sv
// Combinational slot walk: first enabled, opaque layer in priority order wins,
// otherwise an opaque background, otherwise the transparent key.
module graphics_priority_mux #(
    parameter int                  NUM_LAYERS  = 5,
    parameter int                  COLOR_W     = 8,
    parameter int                  IDX_W       = $clog2(NUM_LAYERS),
    parameter logic [COLOR_W-1:0]  TRANSPARENT = '0
) (
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic [NUM_LAYERS*IDX_W-1:0]   order,
    input  logic [COLOR_W-1:0]            bg_color,
    output logic [COLOR_W-1:0]            pixel
);

    logic found;

    // Slot indices that match no layer (>= NUM_LAYERS) simply never hit.
    always_comb begin
        pixel = TRANSPARENT;
        found = 1'b0;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                if (!found
                    && order[s*IDX_W +: IDX_W] == IDX_W'(l)
                    && layer_enable[l]
                    && layer_color[l*COLOR_W +: COLOR_W] != TRANSPARENT) begin
                    pixel = layer_color[l*COLOR_W +: COLOR_W];
                    found = 1'b1;
                end
            end
        end
        if (!found && bg_color != TRANSPARENT) begin
            pixel = bg_color;
        end
    end

endmodule

// File: rtl/graphics_compositor.sv
// Three-stage pixel pipeline: VGA counters -> playfield coords/maze address,
// sprite capture aligned to RAM latency, then priority compositing.
module graphics_compositor
    import graphics_pkg::*;
#(
    parameter int                  NUM_LAYERS  = 5,
    parameter int                  COLOR_W     = 8,
    parameter int                  H_ACTIVE    = 640,
    parameter int                  V_ACTIVE    = 480,
    parameter int                  SCALE_SHIFT = 1,
    parameter int                  XMAX        = PF_XMAX,
    parameter int                  YMAX        = PF_YMAX,
    parameter int                  YOFFSET     = PF_YOFFSET,
    parameter int                  MAZE_W      = PF_MAZE_W,
    parameter int                  ADDR_W      = 16,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = KEY_TRANSPARENT,
    parameter int                  IDX_W       = $clog2(NUM_LAYERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9:0]                    hc,
    input  logic [9:0]                    vc,
    output logic [8:0]                    xpos,
    output logic [8:0]                    ypos,
    output logic [ADDR_W-1:0]             address,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic [COLOR_W-1:0]            bg_color,
    input  logic                          prio_wr,
    input  logic [NUM_LAYERS*IDX_W-1:0]   prio_data,
    output logic                          prio_pending,
    output logic [COLOR_W-1:0]            color,
    output logic                          color_active
);

    localparam int AW = ADDR_W + 2;
    localparam int OW = NUM_LAYERS * IDX_W;

    function automatic logic [OW-1:0] identity_order();
        logic [OW-1:0] o;
        o = '0;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            o[s*IDX_W +: IDX_W] = IDX_W'(s);
        end
        return o;
    endfunction

    localparam logic [OW-1:0] IDENTITY = identity_order();

    // Stage 1 state
    logic [8:0]        xpos_q, xpos_d;
    logic [8:0]        ypos_q, ypos_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              active1_q, active1_d;
    // Stage 2 state
    logic [NUM_LAYERS*COLOR_W-1:0] lcolor_q, lcolor_d;
    logic [NUM_LAYERS-1:0]         lenable_q, lenable_d;
    logic                          active2_q, active2_d;
    // Stage 3 state
    logic [COLOR_W-1:0] color_q, color_d;
    logic               color_active_q, color_active_d;
    // Priority order
    logic [OW-1:0] order_q, order_d;
    logic [OW-1:0] shadow_q, shadow_d;
    logic          pending_q, pending_d;

    logic [9:0]         hc_s, vc_s, xpos_full;
    logic [AW-1:0]      ypos_w, addr_full;
    logic               boundary;
    logic [COLOR_W-1:0] mux_pixel;

    always_comb begin
        active1_d = (hc < 10'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));
        hc_s      = hc >> SCALE_SHIFT;
        vc_s      = vc >> SCALE_SHIFT;
        xpos_full = 10'(XMAX - 1) - vc_s;
        xpos_d    = active1_d ? xpos_full[8:0] : 9'd0;
        ypos_d    = active1_d ? hc_s[8:0] : 9'd0;

        ypos_w    = AW'(ypos_d);
        addr_full = AW'(xpos_d) * AW'(MAZE_W) + ypos_w - AW'(YOFFSET);
        address_d = '1;
        if (ypos_w >= AW'(YOFFSET) && ypos_w < AW'(YOFFSET + MAZE_W)
            && ypos_w < AW'(YMAX)) begin
            address_d = addr_full[ADDR_W-1:0];
        end
    end

    // Sprite colors are combinational from the stage-1 coords, so capturing
    // here lines them up with the RAM data for the same pixel.
    always_comb begin
        lcolor_d  = layer_color;
        lenable_d = layer_enable;
        active2_d = active1_q;
    end

    graphics_priority_mux #(
        .NUM_LAYERS  (NUM_LAYERS),
        .COLOR_W     (COLOR_W),
        .IDX_W       (IDX_W),
        .TRANSPARENT (TRANSPARENT)
    ) u_prio_mux (
        .layer_color  (lcolor_q),
        .layer_enable (lenable_q),
        .order        (order_q),
        .bg_color     (bg_color),
        .pixel        (mux_pixel)
    );

    always_comb begin
        color_d        = active2_q ? mux_pixel : '0;
        color_active_d = active2_q;
    end

    // A write on the boundary cycle lands in the shadow only; the shadow that
    // was already waiting is what gets promoted.
    always_comb begin
        boundary  = (hc == 10'd0) && (vc == 10'(V_ACTIVE));
        order_d   = order_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (boundary) begin
            order_d   = shadow_q;
            pending_d = 1'b0;
        end
        if (prio_wr) begin
            shadow_d  = prio_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos_q         <= '0;
            ypos_q         <= '0;
            address_q      <= '1;
            active1_q      <= 1'b0;
            lcolor_q       <= '0;
            lenable_q      <= '0;
            active2_q      <= 1'b0;
            color_q        <= '0;
            color_active_q <= 1'b0;
            order_q        <= IDENTITY;
            shadow_q       <= IDENTITY;
            pending_q      <= 1'b0;
        end else begin
            xpos_q         <= xpos_d;
            ypos_q         <= ypos_d;
            address_q      <= address_d;
            active1_q      <= active1_d;
            lcolor_q       <= lcolor_d;
            lenable_q      <= lenable_d;
            active2_q      <= active2_d;
            color_q        <= color_d;
            color_active_q <= color_active_d;
            order_q        <= order_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
        end
    end

    assign xpos         = xpos_q;
    assign ypos         = ypos_q;
    assign address      = address_q;
    assign color        = color_q;
    assign color_active = color_active_q;
    assign prio_pending = pending_q;

endmodule

// File: tb/tb_graphics_compositor.sv
// Directed bench for graphics_compositor: coordinates, blanking, compositing
// priority, frame-synchronous order updates and asynchronous reset.
module tb_graphics_compositor;
    import graphics_pkg::*;

    localparam int NL = 5;
    localparam int CW = 8;
    localparam int IW = 3;

    logic             clk;
    logic             rst;
    logic [9:0]       hc, vc;
    logic [8:0]       xpos, ypos;
    logic [15:0]      address;
    logic [NL*CW-1:0] layer_color;
    logic [NL-1:0]    layer_enable;
    logic [CW-1:0]    bg_color;
    logic             prio_wr;
    logic [NL*IW-1:0] prio_data;
    logic             prio_pending;
    logic [CW-1:0]    color;
    logic             color_active;

    int n_checks = 0;
    int n_fail   = 0;

    graphics_compositor dut (
        .clk          (clk),
        .rst          (rst),
        .hc           (hc),
        .vc           (vc),
        .xpos         (xpos),
        .ypos         (ypos),
        .address      (address),
        .layer_color  (layer_color),
        .layer_enable (layer_enable),
        .bg_color     (bg_color),
        .prio_wr      (prio_wr),
        .prio_data    (prio_data),
        .prio_pending (prio_pending),
        .color        (color),
        .color_active (color_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NL*IW-1:0] ord(input int s0, input int s1,
                                             input int s2, input int s3,
                                             input int s4);
        return {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    task automatic set_layers(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                              input logic [CW-1:0] c4);
        layer_color = {c4, 8'h00, 8'h00, c1, c0};
    endtask

    task automatic write_prio(input logic [NL*IW-1:0] o);
        prio_data = o;
        prio_wr   = 1'b1;
        tick(1);
        prio_wr   = 1'b0;
    endtask

    task automatic frame_boundary();
        hc = 10'd0;
        vc = 10'd480;
        tick(1);
        hc = 10'd100;
        vc = 10'd50;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_checks++;
        if (xpos !== 9'd0 || ypos !== 9'd0 || address !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_coords: xpos=%0d ypos=%0d addr=%h, want 0 0 ffff", xpos, ypos, address);
        end
        n_checks++;
        if (color !== 8'h00 || color_active !== 1'b0 || prio_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: color=%h act=%b pend=%b, want 00 0 0", color, color_active, prio_pending);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_coords();
        hc = 10'd100; vc = 10'd50;
        tick(1);
        n_checks++;
        if (xpos !== 9'd214 || ypos !== 9'd50 || address !== 16'd56522) begin
            n_fail++;
            $display("FAIL coords_100_50: xpos=%0d ypos=%0d addr=%0d, want 214 50 56522", xpos, ypos, address);
        end
        hc = 10'd20;
        tick(1);
        n_checks++;
        if (xpos !== 9'd214 || ypos !== 9'd10 || address !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL coords_20_50: xpos=%0d ypos=%0d addr=%h, want 214 10 ffff", xpos, ypos, address);
        end
    endtask

    task automatic test_blanking();
        set_layers(RED, 8'h00, YLW);
        layer_enable = '1;
        bg_color = BLU;
        hc = 10'd700; vc = 10'd10;
        tick(1);
        n_checks++;
        if (xpos !== 9'd0 || ypos !== 9'd0 || address !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL blank_coords: xpos=%0d ypos=%0d addr=%h, want 0 0 ffff", xpos, ypos, address);
        end
        tick(2);
        n_checks++;
        if (color !== 8'h00 || color_active !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_color: color=%h act=%b, want 00 0", color, color_active);
        end
    endtask

    task automatic test_default_priority();
        hc = 10'd100; vc = 10'd50;
        set_layers(RED, 8'h00, YLW);
        layer_enable = '1;
        bg_color = BLU;
        tick(3);
        n_checks++;
        if (color !== RED || color_active !== 1'b1) begin
            n_fail++;
            $display("FAIL default_red: color=%h act=%b, want %h 1", color, color_active, RED);
        end
        layer_enable = 5'b11110;
        tick(3);
        n_checks++;
        if (color !== YLW) begin
            n_fail++;
            $display("FAIL disable_l0: color=%h, want %h", color, YLW);
        end
        layer_enable = '1;
        set_layers(8'h00, 8'h00, 8'h00);
        tick(3);
        n_checks++;
        if (color !== BLU) begin
            n_fail++;
            $display("FAIL bg_only: color=%h, want %h", color, BLU);
        end
        bg_color = 8'h00;
        tick(1);
        n_checks++;
        if (color !== 8'h00 || color_active !== 1'b1) begin
            n_fail++;
            $display("FAIL all_transparent: color=%h act=%b, want 00 1", color, color_active);
        end
        bg_color = BLU;
    endtask

    task automatic test_prio_reprogram();
        set_layers(RED, 8'h00, YLW);
        layer_enable = '1;
        hc = 10'd100; vc = 10'd50;
        write_prio(ord(4, 0, 1, 2, 3));
        n_checks++;
        if (prio_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_set: pend=%b, want 1", prio_pending);
        end
        tick(3);
        n_checks++;
        if (color !== RED) begin
            n_fail++;
            $display("FAIL old_order_holds: color=%h, want %h", color, RED);
        end
        frame_boundary();
        n_checks++;
        if (prio_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_clear: pend=%b, want 0", prio_pending);
        end
        tick(3);
        n_checks++;
        if (color !== YLW) begin
            n_fail++;
            $display("FAIL new_order: color=%h, want %h", color, YLW);
        end
    endtask

    task automatic test_last_write_wins();
        set_layers(RED, CYN, YLW);
        layer_enable = '1;
        write_prio(ord(1, 0, 2, 3, 4));
        tick(1);
        write_prio(ord(0, 1, 2, 3, 4));
        frame_boundary();
        tick(3);
        n_checks++;
        if (color !== RED) begin
            n_fail++;
            $display("FAIL last_write: color=%h, want %h", color, RED);
        end
    endtask

    task automatic test_boundary_collision();
        set_layers(RED, CYN, YLW);
        layer_enable = '1;
        write_prio(ord(4, 0, 1, 2, 3));
        hc = 10'd0; vc = 10'd480;
        prio_data = ord(1, 0, 2, 3, 4);
        prio_wr = 1'b1;
        tick(1);
        prio_wr = 1'b0;
        hc = 10'd100; vc = 10'd50;
        n_checks++;
        if (prio_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_pending: pend=%b, want 1", prio_pending);
        end
        tick(3);
        n_checks++;
        if (color !== YLW) begin
            n_fail++;
            $display("FAIL collide_old_shadow: color=%h, want %h", color, YLW);
        end
        frame_boundary();
        tick(3);
        n_checks++;
        if (color !== CYN || prio_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_next_frame: color=%h pend=%b, want %h 0", color, prio_pending, CYN);
        end
    endtask

    task automatic test_invalid_index();
        set_layers(RED, CYN, YLW);
        layer_enable = '1;
        write_prio(ord(7, 4, 0, 7, 7));
        frame_boundary();
        tick(3);
        n_checks++;
        if (color !== YLW) begin
            n_fail++;
            $display("FAIL invalid_idx: color=%h, want %h", color, YLW);
        end
    endtask

    task automatic test_reset_midframe();
        set_layers(RED, CYN, YLW);
        layer_enable = '1;
        hc = 10'd100; vc = 10'd50;
        write_prio(ord(1, 0, 2, 3, 4));
        tick(2);
        rst = 1'b1;
        #1;
        n_checks++;
        if (xpos !== 9'd0 || address !== 16'hFFFF || color !== 8'h00
            || color_active !== 1'b0 || prio_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: xpos=%0d addr=%h color=%h act=%b pend=%b, want 0 ffff 00 0 0",
                     xpos, address, color, color_active, prio_pending);
        end
        tick(2);
        rst = 1'b0;
        tick(2);
        n_checks++;
        if (color_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_latency_early: act=%b, want 0", color_active);
        end
        tick(1);
        n_checks++;
        if (color !== RED || color_active !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_identity: color=%h act=%b, want %h 1", color, color_active, RED);
        end
    endtask

    initial begin
        rst          = 1'b1;
        hc           = 10'd0;
        vc           = 10'd0;
        layer_color  = '0;
        layer_enable = '0;
        bg_color     = '0;
        prio_wr      = 1'b0;
        prio_data    = '0;
        test_reset();
        test_coords();
        test_blanking();
        test_default_priority();
        test_prio_reprogram();
        test_last_write_wins();
        test_boundary_collision();
        test_invalid_index();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
